hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised stall-and-forward controller for the in-order MIPS pipeline. It replaces decode-time instruction-pair comparison with a per-register scoreboard that tracks each pending write through the stages after D (default E/M/W). Each entry carries a ready countdown, so the block produces `stall` and per-read-port forwarding selects for any number of read ports and stages. It also tracks a multi-cycle mul/div unit with its own busy counter, which stalls HI/LO users in D.

## Interface
- `NREG`, 32: architectural registers; register 0 is hard-wired zero.
- `AW`, 5: register address width, equal to clog2(NREG).
- `NRD`, 2: D-stage read ports (rs, rt, ...).
- `NSTG`, 3: pipeline stages after D that can hold a producer (E, M, W).
- `TW`, 2: width of Tuse/Tnew fields.
- `MUL_LAT`, 5: mul busy cycles.
- `DIV_LAT`, 10: div busy cycles.
- `SW`: derived, clog2(NSTG+1), the fwd-select width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `d_valid`  in  1  D holds a real instruction.
- `d_ra`  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- `d_tuse`  in  NRD*TW  cycles from D until port i's value is consumed; all-ones means the port is unused.
- `d_wr`  in  1  the instruction writes the GRF.
- `d_wa`  in  AW  destination register.
- `d_tnew`  in  TW  cycles after entering E until the result is forwardable.
- `d_md_start`  in  1  the instruction starts mul/div.
- `d_md_div`  in  1  selects div (1) or mul (0); valid with `d_md_start`.
- `d_md_use`  in  1  the instruction reads or writes HI/LO, or starts mul/div.
- `stall`  out  1  freezes F/D and inserts a bubble into E.
- `fwd_sel`  out  NRD*SW  per port: 0 = GRF, k = stage k (1 = E, 2 = M, 3 = W).
- `md_busy`  out  1  mul/div counter is non-zero.

## Operation
- Scoreboard entry per register r (1..NREG-1) holds:
  - `pend`
  - `age` (0..NSTG-1; 0 means the producer is in E)
  - `rdy` (TW bits, cycles until forwardable)
- Data hazard for port i with address a, where a != 0 and `d_tuse[i]` is not all-ones:
  - `haz[i] = pend[a] && (rdy[a] > d_tuse[i])`
- Mul/div hazard:
  - `md_haz = d_md_use && (md_cnt != 0)`
- `stall = d_valid && (|haz || md_haz)`. The output is combinational from current state and D inputs only.
- `fwd_sel[i] = (a != 0 && pend[a]) ? age[a] + 1 : 0`. It is reported even while stalled; the consumer re-evaluates it each cycle.
- `issue = d_valid && !stall`.
- Per cycle, for every pending entry:
  - `age` increments and `rdy` decrements, saturating at 0.
  - An entry at `age == NSTG-1` clears `pend`, because the producer leaves W.
- On issue with `d_wr && d_wa != 0`:
  - Entry `d_wa` is loaded with `pend=1, age=0, rdy=d_tnew`.
  - This overrides aging or clearing of that entry in the same cycle, so the newest producer always wins.
- A stalled D issues nothing. The bubble in E is implicit: existing entries keep aging.
- On issue with `d_md_start`, `md_cnt` loads `DIV_LAT` if `d_md_div`, otherwise `MUL_LAT`. Otherwise `md_cnt` decrements, saturating at 0.
- An issuing instruction's hazard check uses pre-update state. An instruction that reads and writes the same register compares only against older producers.

## Timing
- Reset (asynchronous on `reset` low):
  - All `pend`, `age`, `rdy` and `md_cnt` clear to 0.
  - Outputs are therefore `stall=0`, `fwd_sel=0`, `md_busy=0`.
  - Reset mid-stall or mid-mul/div drops all tracking immediately.
- Stall resolves in `rdy - tuse` cycles. Example: a load (`tnew`=2) followed immediately by a `tuse`=1 consumer gives 1 stall cycle; a `tuse`=0 branch gives 2.
- Writes to register 0 never create entries. Reads of register 0 never stall and report `fwd_sel`=0.
- A producer at W is cleared on the next edge. Afterwards the GRF supplies the value (`fwd_sel`=0).
- `md_busy` rises the cycle after the issuing start. It stays high exactly LAT cycles.
- A `d_md_start` presented while `md_cnt != 0` stalls. It is not queued.
- Simultaneous issue-write and W-exit of the same register: the entry reloads (`pend` stays 1, `age`=0).

## Test plan
- Load-use, `NRD`=2:
  - lw $8 (`tnew`=2), then add reading $8 on port 0 (`tuse`=1).
  - Required: `stall`=1 for 1 cycle; next cycle `fwd_sel[0]`=2 (M); no stall.
- Branch after ALU:
  - addu $9 (`tnew`=1), then beq reading $9 (`tuse`=0).
  - Required: 1 stall, then `fwd_sel`=2; with one independent instruction between them, 0 stalls and `fwd_sel`=2.
- Overwrite ordering:
  - lw $5, then addu $5 (`tnew`=1), then a `tuse`=1 reader of $5.
  - Required: no stall; `fwd_sel`=1 (E, the newest producer), not M.
- Register zero:
  - `d_wa`=0 with `d_wr`=1, then reader of $0 with `tuse`=0.
  - Required: `stall`=0, `fwd_sel`=0, no entry set.
- Mul/div:
  - div issues (`DIV_LAT`=10), then mflo.
  - Required: `md_busy`=1 for exactly 10 cycles; mflo stalls until `md_cnt`=0, then issues; a mult issued during busy also stalls.
- Async reset:
  - Assert `reset` low mid-div with a pending load entry.
  - Required: `stall`, `md_busy` and `fwd_sel` drop to 0 without a clock edge; a later reader of the former destination does not stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard producing stall and forwarding selects, plus mul/div busy tracking
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int NSTG    = 3,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  localparam int SW     = $clog2(NSTG + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [NRD*AW-1:0] d_ra,
  input  logic [NRD*TW-1:0] d_tuse,
  input  logic              d_wr,
  input  logic [AW-1:0]     d_wa,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [NRD*SW-1:0] fwd_sel,
  output logic              md_busy
);
  localparam int AGW  = NSTG > 1 ? $clog2(NSTG) : 1;
  localparam int MAXL = DIV_LAT > MUL_LAT ? DIV_LAT : MUL_LAT;
  localparam int MW   = $clog2(MAXL + 1);
  logic           pend [NREG];
  logic [AGW-1:0] age  [NREG];
  logic [TW-1:0]  rdy  [NREG];
  logic [MW-1:0]  md_cnt;
  logic [NRD-1:0] haz;
  logic           issue;
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] a;
    logic [TW-1:0] tu;
    logic          live;
    assign a    = d_ra[i*AW +: AW];
    assign tu   = d_tuse[i*TW +: TW];
    assign live = (a != '0) && pend[a];
    assign haz[i] = live && (tu != '1) && (rdy[a] > tu);
    assign fwd_sel[i*SW +: SW] = live ? SW'(age[a]) + SW'(1) : '0;
  end
  assign md_busy = md_cnt != '0;
  assign stall   = d_valid && (|haz || (d_md_use && md_busy));
  assign issue   = d_valid && !stall;
  // age pending producers, retire them past W, and let a newly issued writer override its entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= 1'b0;
        age[r]  <= '0;
        rdy[r]  <= '0;
      end
      md_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (issue && d_wr && d_wa != '0 && d_wa == AW'(r)) begin
          pend[r] <= 1'b1;
          age[r]  <= '0;
          rdy[r]  <= d_tnew;
        end else if (pend[r]) begin
          pend[r] <= age[r] != AGW'(NSTG - 1);
          age[r]  <= (age[r] == AGW'(NSTG - 1)) ? '0 : age[r] + 1'b1;
          rdy[r]  <= (rdy[r] != '0) ? rdy[r] - 1'b1 : '0;
        end
      end
      md_cnt <= (issue && d_md_start) ? (d_md_div ? MW'(DIV_LAT) : MW'(MUL_LAT))
              : (md_cnt != '0) ? md_cnt - 1'b1 : '0;
    end
  end
endmodule
